cvtshift_iter: RTL and testbench

Iterative, handshaked successor to the FPU conversion shift-calculation logic. It selects the conversion shifter input and computes the underflow flag, then performs the normalising left shift itself over several cycles, `BITS_PER_CYC` shift-amount bits per cycle. It sits between the conversion exponent/LZC stage and the rounder in the multi-cycle FPU conversion path. It is fully parametrised in width, number of formats and shift throughput.

---
 rtl/cvtshift_pkg.sv | 29 ++
 rtl/cvtshift_step.sv | 29 ++
 rtl/cvtshift_iter.sv | 141 ++++++++++++++
 tb/tb_cvtshift_iter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvtshift_pkg.sv
// Shared types and helpers for the iterative conversion shifter.
package cvtshift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cvtshift_state_t;

  // Fraction length per output format: single, double, half, quad
  localparam int FRAC_LEN [4] = '{23, 52, 10, 112};

  function automatic int calc_logsh(input int shw);
    return $clog2(shw);
  endfunction

  function automatic int calc_niter(input int logsh, input int bpc);
    return (logsh + bpc - 1) / bpc;
  endfunction

  // Formats wider than the datapath are clipped to the widest fraction we carry
  function automatic int frac_len(input int fmt, input int nf);
    int f;
    if (fmt >= 0 && fmt < 4) f = FRAC_LEN[fmt];
    else f = nf;
    return (f > nf) ? nf : f;
  endfunction

endpackage

// File: rtl/cvtshift_step.sv
// One iteration of the normalising shift: BITS_PER_CYC log-shifter stages
// driven by the shift-amount bits selected by the iteration index.
module cvtshift_step #(
  parameter int SHW          = 118,
  parameter int LOGSH        = 7,
  parameter int BITS_PER_CYC = 2,
  parameter int CNTW         = 3
) (
  input  logic [SHW-1:0]   din,
  input  logic [LOGSH-1:0] amt,
  input  logic [CNTW-1:0]  idx,
  output logic [SHW-1:0]   dout
);

  logic [SHW-1:0] stage;

  // Amount bits past LOGSH in the last iteration are treated as zero
  always_comb begin
    stage = din;
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      if ((int'(idx) * BITS_PER_CYC + j) < LOGSH) begin
        if (amt[int'(idx) * BITS_PER_CYC + j])
          stage = stage << (1 << (int'(idx) * BITS_PER_CYC + j));
      end
    end
    dout = stage;
  end

endmodule

// File: rtl/cvtshift_iter.sv
// Iterative handshaked conversion shifter: input select, underflow flag, multi-cycle left shift.
// Optional abort input enabled by defining CVTSHIFT_FLUSH_EN.
module cvtshift_iter
  import cvtshift_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NF           = 52,
  parameter int NE           = 11,
  parameter int CVTLEN       = 65,
  parameter int FMTBITS      = 2,
  parameter int BITS_PER_CYC = 2,
  localparam int SHW         = CVTLEN + NF + 1,
  localparam int LOGSH       = calc_logsh(SHW)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic               XZero,
  input  logic               ToInt,
  input  logic               IntToFp,
  input  logic               CvtResSubnormUf,
  input  logic [FMTBITS-1:0] OutFmt,
  input  logic [NE:0]        CvtCe,
  input  logic [NF:0]        Xm,
  input  logic [CVTLEN-1:0]  CvtLzcIn,
  input  logic [LOGSH-1:0]   ShiftAmt,
`ifdef CVTSHIFT_FLUSH_EN
  input  logic               Flush,
`endif
  output logic               OutValid,
  input  logic               OutReady,
  output logic [SHW-1:0]     CvtShiftOut,
  output logic               CvtResUf
);

  localparam int NITER = calc_niter(LOGSH, BITS_PER_CYC);
  localparam int CNTW  = $clog2(NITER + 1);

  cvtshift_state_t  state;
  logic [SHW-1:0]   sh_reg;
  logic [SHW-1:0]   sel_in;
  logic [SHW-1:0]   step_out;
  logic [LOGSH-1:0] amt_q;
  logic [CNTW-1:0]  cnt;
  logic             uf_next;
  logic             uf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             flush_i;

`ifdef CVTSHIFT_FLUSH_EN
  assign flush_i = Flush;
`else
  assign flush_i = 1'b0;
`endif

  // ToInt folds the implicit one into the sticky slot when the exponent is negative
  always_comb begin
    sel_in = '0;
    if (ToInt)
      sel_in = {{XLEN{1'b0}}, Xm[NF] & ~CvtCe[NE], Xm[NF-1] | (CvtCe[NE] & Xm[NF]),
                Xm[NF-2:0], {(CVTLEN-XLEN){1'b0}}};
    else if (CvtResSubnormUf)
      sel_in = {{(NF-1){1'b0}}, Xm, {(CVTLEN-NF+1){1'b0}}};
    else
      sel_in = {CvtLzcIn, {(NF+1){1'b0}}};
  end

  assign uf_next = ~XZero & ~IntToFp & ~ToInt &
                   (int'($signed(CvtCe)) < -frac_len(int'(OutFmt), NF));

  cvtshift_step #(
    .SHW          (SHW),
    .LOGSH        (LOGSH),
    .BITS_PER_CYC (BITS_PER_CYC),
    .CNTW         (CNTW)
  ) u_step (
    .din  (sh_reg),
    .amt  (amt_q),
    .idx  (cnt),
    .dout (step_out)
  );

  // Control and datapath; flush outranks both accept and the output handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sh_reg      <= '0;
      amt_q       <= '0;
      cnt         <= '0;
      uf_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            sh_reg     <= sel_in;
            amt_q      <= ShiftAmt;
            cnt        <= '0;
            uf_q       <= uf_next;
            in_ready_q <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sh_reg <= step_out;
          cnt    <= cnt + 1'b1;
          if (cnt == CNTW'(NITER - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (OutReady) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign InReady     = in_ready_q;
  assign OutValid    = out_valid_q;
  assign CvtShiftOut = sh_reg;
  assign CvtResUf    = uf_q;

endmodule

// File: tb/tb_cvtshift_iter.sv
// Scoreboard bench for cvtshift_iter; exercises Flush when CVTSHIFT_FLUSH_EN is defined.
module tb_cvtshift_iter;

  localparam int XLEN   = 64;
  localparam int NF     = 52;
  localparam int NE     = 11;
  localparam int CVTLEN = 65;
  localparam int BPC    = 2;
  localparam int SHW    = CVTLEN + NF + 1;
  localparam int LOGSH  = 7;
  localparam int NITER  = (LOGSH + BPC - 1) / BPC;

  typedef struct packed {
    logic [SHW-1:0] sh;
    logic           uf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              InValid = 1'b0;
  logic              InReady;
  logic              XZero = 1'b0, ToInt = 1'b0, IntToFp = 1'b0, CvtResSubnormUf = 1'b0;
  logic [1:0]        OutFmt = 2'd1;
  logic [NE:0]       CvtCe = '0;
  logic [NF:0]       Xm = '0;
  logic [CVTLEN-1:0] CvtLzcIn = '0;
  logic [LOGSH-1:0]  ShiftAmt = '0;
  logic              OutValid;
  logic              OutReady = 1'b0;
  logic [SHW-1:0]    CvtShiftOut;
  logic              CvtResUf;
`ifdef CVTSHIFT_FLUSH_EN
  logic              Flush = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  cvtshift_iter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .InValid         (InValid),
    .InReady         (InReady),
    .XZero           (XZero),
    .ToInt           (ToInt),
    .IntToFp         (IntToFp),
    .CvtResSubnormUf (CvtResSubnormUf),
    .OutFmt          (OutFmt),
    .CvtCe           (CvtCe),
    .Xm              (Xm),
    .CvtLzcIn        (CvtLzcIn),
    .ShiftAmt        (ShiftAmt),
`ifdef CVTSHIFT_FLUSH_EN
    .Flush           (Flush),
`endif
    .OutValid        (OutValid),
    .OutReady        (OutReady),
    .CvtShiftOut     (CvtShiftOut),
    .CvtResUf        (CvtResUf)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference built bit-by-bit, then a single full-width shift
  function automatic exp_t model(input logic toint, input logic subuf, input logic xzero,
                                 input logic inttofp, input logic [1:0] fmt,
                                 input logic [NE:0] ce, input logic [NF:0] xm,
                                 input logic [CVTLEN-1:0] lzc, input logic [LOGSH-1:0] amt);
    exp_t r;
    logic [SHW-1:0] v;
    int fl;
    v = '0;
    if (toint) begin
      v[SHW-XLEN-1] = xm[NF] & ~ce[NE];
      v[SHW-XLEN-2] = xm[NF-1] | (ce[NE] & xm[NF]);
      for (int i = 0; i < NF - 1; i++) v[CVTLEN-XLEN+i] = xm[i];
    end else if (subuf) begin
      for (int i = 0; i <= NF; i++) v[CVTLEN-NF+1+i] = xm[i];
    end else begin
      for (int i = 0; i < CVTLEN; i++) v[NF+1+i] = lzc[i];
    end
    r.sh = (int'(amt) >= SHW) ? '0 : (v << amt);
    case (fmt)
      2'd0: fl = 23;
      2'd1: fl = 52;
      2'd2: fl = 10;
      default: fl = 52;
    endcase
    r.uf = !xzero && !inttofp && !toint && (int'($signed(ce)) < -fl);
    return r;
  endfunction

  task automatic applyStimulus(input logic toint, input logic subuf, input logic xzero,
                               input logic inttofp, input logic [1:0] fmt,
                               input logic [NE:0] ce, input logic [NF:0] xm,
                               input logic [CVTLEN-1:0] lzc, input logic [LOGSH-1:0] amt);
    @(negedge clk);
    checkOutput("in_ready_idle", 128'(InReady), 128'(1));
    ToInt = toint; CvtResSubnormUf = subuf; XZero = xzero; IntToFp = inttofp;
    OutFmt = fmt; CvtCe = ce; Xm = xm; CvtLzcIn = lzc; ShiftAmt = amt;
    InValid = 1'b1;
    sbq.push_back(model(toint, subuf, xzero, inttofp, fmt, ce, xm, lzc, amt));
    @(posedge clk);
    #1;
    InValid = 1'b0;
    checkOutput("in_ready_busy", 128'(InReady), 128'(0));
  endtask

  task automatic checkResult(input int bp);
    exp_t e;
    int   lat;
    bit   got;
    lat = 0;
    got = 1'b0;
    if (bp == 0) OutReady = 1'b1;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (OutValid === 1'b1) got = 1'b1;
    end
    checkOutput("latency", 128'(lat), 128'(NITER));
    if (sbq.size() == 0) begin
      checkOutput("sbq_empty", 128'(1), 128'(0));
      OutReady = 1'b0;
      return;
    end
    e = sbq.pop_front();
    if (!got) begin
      OutReady = 1'b0;
      return;
    end
    checkOutput("shift_out", 128'(CvtShiftOut), 128'(e.sh));
    checkOutput("res_uf", 128'(CvtResUf), 128'(e.uf));
    checkOutput("in_ready_done", 128'(InReady), 128'(0));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 128'(OutValid), 128'(1));
      checkOutput("hold_data", 128'(CvtShiftOut), 128'(e.sh));
      checkOutput("hold_in_ready", 128'(InReady), 128'(0));
    end
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    OutReady = 1'b0;
    checkOutput("post_hs_valid", 128'(OutValid), 128'(0));
    checkOutput("post_hs_ready", 128'(InReady), 128'(1));
  endtask

  initial begin
    logic [NF:0]       rxm;
    logic [CVTLEN-1:0] rlzc;
    logic [NF:0]       xm1;
    logic [CVTLEN-1:0] lzc1;
    logic [SHW-1:0]    bit58;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 128'(OutValid), 128'(0));
    checkOutput("rst_in_ready", 128'(InReady), 128'(1));
    checkOutput("rst_shift_out", 128'(CvtShiftOut), 128'(0));
    checkOutput("rst_res_uf", 128'(CvtResUf), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    xm1  = '0; xm1[NF] = 1'b1;
    lzc1 = '0; lzc1[0] = 1'b1;
    bit58 = '0; bit58[58] = 1'b1;

    // FP->FP normalisation, cross-checked against a hand constant
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'sd0, xm1, lzc1, 7'd5);
    checkOutput("ref_bit58", 128'(sbq[0].sh), 128'(bit58));
    checkResult(0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, -12'sd53, xm1, lzc1, 7'd3);
    checkResult(0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, -12'sd52, xm1, lzc1, 7'd3);
    checkResult(0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, -12'sd24, xm1, lzc1, 7'd1);
    checkResult(0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, -12'sd100, xm1, lzc1, 7'd1);
    checkResult(0);

    // ToInt with negative exponent lands the one in the sticky slot
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, -12'sd1, xm1, lzc1, 7'd0);
    checkOutput("ref_sticky", 128'(sbq[0].sh[SHW-XLEN-2]), 128'(1));
    checkResult(0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, -12'sd60, 53'h1F_0000_1234_5678, lzc1, 7'd9);
    checkResult(3);

    rlzc = (CVTLEN)'({$urandom, $urandom, $urandom});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 12'sd5, xm1, rlzc, 7'd17);
    checkResult(10);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'sd0, xm1, '1, 7'd127);
    checkOutput("ref_oversize", 128'(sbq[0].sh), 128'(0));
    checkResult(0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'sd0, xm1, lzc1, 7'd117);
    checkResult(0);
    lzc1 = '0; lzc1[CVTLEN-1] = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'sd0, xm1, lzc1, 7'd0);
    checkResult(0);

    for (int n = 0; n < 8; n++) begin
      rxm  = (NF+1)'({$urandom, $urandom});
      rlzc = (CVTLEN)'({$urandom, $urandom, $urandom});
      applyStimulus(1'(n % 3 == 0), 1'(n % 3 == 1), 1'($urandom_range(0, 1)), 1'(n == 5),
                    2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)), rxm, rlzc,
                    7'($urandom_range(0, 127)));
      checkResult(n % 4);
    end

    // Reset in the middle of SHIFT drops the operation
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'sd0, xm1, lzc1, 7'd2);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 128'(OutValid), 128'(0));
    checkOutput("midrst_ready", 128'(InReady), 128'(1));
    checkOutput("midrst_data", 128'(CvtShiftOut), 128'(0));
    checkOutput("midrst_uf", 128'(CvtResUf), 128'(0));
    void'(sbq.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, -12'sd53, xm1, lzc1, 7'd33);
    checkResult(0);

`ifdef CVTSHIFT_FLUSH_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'sd0, xm1, lzc1, 7'd4);
    repeat (NITER) @(posedge clk);
    #1;
    checkOutput("flush_pre_valid", 128'(OutValid), 128'(1));
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    checkOutput("flush_valid", 128'(OutValid), 128'(0));
    checkOutput("flush_ready", 128'(InReady), 128'(1));
    void'(sbq.pop_back());
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, -12'sd30, 53'h0A_BCDE_F012_3456, lzc1, 7'd21);
    checkResult(2);
`endif

    checkOutput("sbq_drained", 128'(sbq.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
